// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, one sign-fixup cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam logic [2:0]  OP_MTHI = 3'd4;
  localparam logic [2:0]  OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;

  logic             accept_c;
  logic             md_op_c;
  logic             div_op_c;
  logic             signed_op_c;
  logic             zero_div_c;
  logic             last_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_rem_c;
  logic [WIDTH:0]   div_diff_c;
  logic [PW-1:0]    step_c;
  logic [PW-1:0]    product_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Op decode; flush in IDLE squashes any same-cycle request
  assign accept_c    = (state_q == S_IDLE) && start && !flush;
  assign md_op_c     = !op[2];
  assign div_op_c    = op[1];
  assign signed_op_c = !op[0];
  assign zero_div_c  = div_op_c && (rt == '0);
  assign last_c      = (cnt_q == CNT_W'(WIDTH - 1));

  // One radix-2 iteration; acc holds {partial, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_rem_c  = acc_q[PW-1:WIDTH-1];
    div_diff_c = div_rem_c - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_diff_c[WIDTH]) begin
        step_c = {div_rem_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        step_c = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fixup applied in the SIGN cycle
  assign product_c = neg_res_q ? (~acc_q + PW'(1)) : acc_q;
  assign quot_c    = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_c     = neg_rem_q ? (~acc_q[PW-1:WIDTH] + WIDTH'(1)) : acc_q[PW-1:WIDTH];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c && md_op_c) begin
          state_d = zero_div_c ? S_SIGN : S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_c) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (md_op_c) begin
            cnt_d     = '0;
            is_div_d  = div_op_c;
            dbz_d     = zero_div_c;
            neg_res_d = signed_op_c && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_rem_d = signed_op_c && rs[WIDTH-1];
            if (zero_div_c) begin
              opnd_d = rt;
              acc_d  = {{WIDTH{1'b0}}, rs};
            end else if (div_op_c) begin
              opnd_d = magnitude(rt, signed_op_c);
              acc_d  = {{WIDTH{1'b0}}, magnitude(rs, signed_op_c)};
            end else begin
              opnd_d = magnitude(rs, signed_op_c);
              acc_d  = {{WIDTH{1'b0}}, magnitude(rt, signed_op_c)};
            end
          end else if (op == OP_MTHI) begin
            hi_d = rs;
          end else if (op == OP_MTLO) begin
            lo_d = rs;
          end
        end
      end
      S_RUN: begin
        if (!flush) begin
          acc_d = step_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SIGN: begin
        if (!flush) begin
          done_d    = 1'b1;
          dbz_out_d = dbz_q;
          if (dbz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_c;
            lo_d = quot_c;
          end else begin
            hi_d = product_c[PW-1:WIDTH];
            lo_d = product_c[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_by_zero queued at issue,
// popped and compared whenever done pulses.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard consumer
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_hi", 64'(hi), 64'(e.hi));
        check_eq("sb_lo", 64'(lo), 64'(e.lo));
        check_eq("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Single-cycle start request; returns #1 after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat    = lat0;
    busy_n = 0;
    while (lat < 200) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) break;
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edbz, input int exp_lat, output int busy_n);
    int lat;
    sb_q.push_back('{hi: eh, lo: el, dbz: edbz});
    issue(o, a, b);
    wait_done(0, lat, busy_n);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic move_to(input string tag, input logic [2:0] o, input logic [W-1:0] v);
    issue(o, v, '0);
    @(negedge clock);
    check_eq({tag, "_val"}, (o == 3'd4) ? 64'(hi) : 64'(lo), 64'(v));
    check_eq({tag, "_nodone"}, 64'(done), 64'd0);
    check_eq({tag, "_nobusy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int busy_n;
    int lat;
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    rs    = '0;
    rt    = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);

    // Multiply signed / unsigned
    run_md("mult", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, busy_n);
    check_eq("mult_busy_cycles", 64'(busy_n), 64'd33);
    run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, 33, busy_n);
    run_md("mult_neg_neg", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, 1'b0, 33, busy_n);

    // Divide signed / unsigned / overflow
    run_md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, busy_n);
    run_md("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, busy_n);
    run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, busy_n);
    run_md("div_pos_neg", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 33, busy_n);

    // Divide by zero, short path
    run_md("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1, busy_n);
    check_eq("divu_zero_busy_cycles", 64'(busy_n), 64'd1);

    // start while busy is ignored
    move_to("t4_mthi0", 3'd4, 32'h0);
    move_to("t4_mtlo0", 3'd5, 32'h0);
    sb_q.push_back('{hi: 32'h0, lo: 32'd15, dbz: 1'b0});
    issue(3'd1, 32'd3, 32'd5);
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    op    = 3'd2;
    rs    = 32'd100;
    rt    = 32'd10;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(10, lat, busy_n);
    check_eq("t4_latency", 64'(lat), 64'd33);
    repeat (3) @(negedge clock);
    check_eq("t4_div_dropped", 64'(busy), 64'd0);
    move_to("t4_mthi", 3'd4, 32'hA5A5_A5A5);

    // flush mid-operation
    move_to("t5_mthi", 3'd4, 32'h1111_1111);
    move_to("t5_mtlo", 3'd5, 32'h1111_1111);
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    check_eq("t5_busy", 64'(busy), 64'd0);
    check_eq("t5_hi", 64'(hi), 64'h1111_1111);
    check_eq("t5_lo", 64'(lo), 64'h1111_1111);
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check_eq("t5_no_done", 64'(done_seen), 64'd0);

    // flush in IDLE beats a same-cycle start
    @(negedge clock);
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd4;
    rs    = 32'hDEAD_BEEF;
    @(posedge clock);
    #1 start = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    check_eq("t5_idle_mthi_dropped", 64'(hi), 64'h1111_1111);
    @(negedge clock);
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd1;
    rs    = 32'd9;
    rt    = 32'd9;
    @(posedge clock);
    #1 start = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    check_eq("t5_idle_mult_dropped", 64'(busy), 64'd0);

    // reset mid-divide
    issue(3'd2, 32'd100, 32'd7);
    repeat (11) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("t6_hi", 64'(hi), 64'd0);
    check_eq("t6_lo", 64'(lo), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_done", 64'(done), 64'd0);
    run_md("t6_multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, busy_n);

    repeat (3) @(negedge clock);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits beside the execute-stage ALU and replaces its single-cycle combinational MULT/DIV and HI/LO handling.
- Adds signed and unsigned variants, MTHI/MTLO, divide-by-zero reporting, a busy interlock used by the hazard unit to stall MFHI/MFLO and new mult/div ops, and a flush input for squashing on taken branches.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  Single clock. All state updates on its rising edge.
- reset  input  1  Synchronous, active-high.
- start  input  1  Request a new operation. Sampled only in IDLE.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are treated as no-op.
- rs  input  WIDTH  Operand A: multiplicand or dividend. Also the MTHI/MTLO source.
- rt  input  WIDTH  Operand B: multiplier or divisor.
- flush  input  1  Abort the in-flight operation.
- busy  output  1  High while in RUN or SIGN.
- done  output  1  One-cycle pulse when HI/LO are updated by a mult/div.
- div_by_zero  output  1  Valid with done; high if the divisor was zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE. Reset overrides all other inputs, including mid-operation; any partial result is discarded.
- States:
  - IDLE. On start with op 0-3, latch the operand magnitudes, the sign flags and the op kind, clear the counter, and go to RUN. busy rises in the cycle after the accepting edge (E0).
  - RUN. Performs one radix-2 iteration per edge, WIDTH iterations in total (E1..E_WIDTH).
    - Multiply: shift-add over a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract, producing quotient and remainder.
    - After the last iteration, go to SIGN.
  - SIGN (edge E_WIDTH+1). Apply sign fixup, write hi/lo, pulse done, clear busy, return to IDLE. done is high for exactly the cycle after E_WIDTH+1. Total latency is WIDTH+1 edges after the accepting edge.
- Signedness:
  - MULT and DIV operate on magnitudes.
  - Product is negated (2*WIDTH two's complement) when the operand signs differ.
  - Quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - MULTU and DIVU skip fixup but still spend the SIGN cycle, so latency is uniform.
- Result mapping:
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
- Overflow case: DIV with most-negative / -1 gives lo=most-negative (wraps) and hi=0. No flag is raised.
- Divide by zero (rt==0 on DIV or DIVU):
  - No iteration; go IDLE -> SIGN directly.
  - Writes hi=rs (raw), lo=all-ones at E1, with done=1 and div_by_zero=1 in the following cycle.
- div_by_zero is low whenever done is low.
- MTHI/MTLO: accepted only in IDLE. Write hi (or lo)=rs at E0. No busy, no done. Op 6/7 with start: ignored.
- start while busy: ignored. No queuing, no effect on the running operation. The hazard unit must hold the requester.
- flush:
  - In RUN or SIGN, the next edge returns to IDLE. busy=0, done=0, hi/lo unchanged.
  - In IDLE, flush suppresses a same-cycle start (flush has priority).
- hi/lo are registered and reflect committed results only. They never show intermediate accumulator values.
- No combinational path from inputs to outputs.

Test Plan (WIDTH=32):
1. MULT rs=0xFFFFFFFF rt=0x00000002 -> done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for 33 cycles. Then MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
2. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
3. DIVU rs=7 rt=0 -> done and div_by_zero high one cycle after E1; hi=7, lo=0xFFFFFFFF. Next mult/div completes with div_by_zero=0.
4. With hi=lo=0, MULTU 3*5 in flight; assert start with DIV 100/10 at edge 10 -> ignored; result hi=0, lo=15. Then MTHI rs=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, no done.
5. MULTU 0x10000*0x10000 started with prior hi=lo=0x11111111; flush at edge 5 -> busy=0 next cycle, done never pulses, hi=lo=0x11111111. A start asserted in the same cycle as flush in IDLE is dropped.
6. reset asserted mid-DIV at edge 12 -> next cycle hi=lo=0, busy=0, done=0. A fresh MULTU 6*7 then gives lo=42 after 33 edges.
